composite_pixel_out: RTL

//  Downstream of the composite sync generator. Consumes row_enable/vblank/sync_signal, tracks pixel column/line,

---
 rtl/composite_pixel_out.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/composite_pixel_out.sv
// Pixel output stage: tracks column/line, fetches framebuffer or test-pattern pixels and drives the 3-bit DAC level.
// Optional macro BORDER_EN forces a gray5 border around the active area.
module composite_pixel_out #(
  parameter int COLS = 104,
  parameter int ROWS = 304,
  parameter int X_W  = 7,
  parameter int Y_W  = 9
) (
  input  logic               syn_clk,
  input  logic               rst,
  input  logic               row_enable,
  input  logic               vblank,
  input  logic [2:0]         sync_signal,
  input  logic [1:0]         mode,
  input  logic [2:0]         fb_data,
  output logic               fb_rd,
  output logic [X_W+Y_W-1:0] fb_addr,
  output logic [2:0]         video_out,
  output logic [Y_W-1:0]     line_count,
  output logic               frame_tick
);

  localparam logic [X_W-1:0] X_END  = X_W'(COLS);
  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  typedef enum logic [1:0] {ST_VBLANK, ST_HWAIT, ST_ACTIVE} state_e;

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [1:0]     mode_q, mode_d;
  logic           issue;
  logic [1:0]     line_mode;

  // Stage 1: fetch/pattern, stage 2: level map; re/sync pipes align with them.
  logic                   fb_rd_q;
  logic [X_W+Y_W-1:0]     fb_addr_q;
  logic [2:0]             idx_s1_q, idx_s1_d;
  logic                   use_fb_q, use_fb_d;
  logic                   re_d1_q, re_d2_q;
  logic [2:0]             sync_d1_q, sync_d2_q;
  logic [2:0]             pix_q;
  logic                   vblank_q, frame_tick_q;
  logic                   border;

  function automatic logic [2:0] idx_to_level(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      3'd2:    return 3'b100;
      3'd3:    return 3'b011;
      3'd4:    return 3'b101;
      3'd5:    return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    mode_d    = mode_q;
    issue     = 1'b0;
    line_mode = (state_q == ST_ACTIVE) ? mode_q : mode;
    if (vblank) begin
      state_d = ST_VBLANK;
      x_d     = '0;
      y_d     = '0;
    end else begin
      case (state_q)
        ST_VBLANK: state_d = ST_HWAIT;
        ST_HWAIT, ST_ACTIVE: begin
          if (row_enable) begin
            state_d = ST_ACTIVE;
            issue   = 1'b1;
            if (state_q == ST_HWAIT) mode_d = mode;
            if (x_q != X_END) x_d = x_q + 1'b1;
          end else if (state_q == ST_ACTIVE) begin
            state_d = ST_HWAIT;
            x_d     = '0;
            if (y_q != Y_LAST) y_d = y_q + 1'b1;
          end
        end
        default: state_d = ST_VBLANK;
      endcase
    end
  end

`ifdef BORDER_EN
  assign border = (x_q == '0) || (x_q == X_LAST) || (y_q == '0) || (y_q == Y_LAST);
`else
  assign border = 1'b0;
`endif

  always_comb begin
    idx_s1_d = 3'd0;
    use_fb_d = 1'b0;
    case (line_mode)
      2'd0:    use_fb_d = 1'b1;
      2'd1:    idx_s1_d = 3'(x_q >> 4);
      2'd2:    idx_s1_d = (x_q[3] ^ y_q[3]) ? 3'd6 : 3'd0;
      default: idx_s1_d = 3'd6;
    endcase
    // The saturated column past the line end always shows black.
    if (x_q >= X_END) begin
      idx_s1_d = 3'd0;
      use_fb_d = 1'b0;
    end else if (border) begin
      idx_s1_d = 3'd6;
      use_fb_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge syn_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_VBLANK;
      x_q          <= '0;
      y_q          <= '0;
      mode_q       <= 2'd0;
      fb_rd_q      <= 1'b0;
      fb_addr_q    <= '0;
      idx_s1_q     <= 3'd0;
      use_fb_q     <= 1'b0;
      re_d1_q      <= 1'b0;
      re_d2_q      <= 1'b0;
      sync_d1_q    <= 3'b000;
      sync_d2_q    <= 3'b000;
      pix_q        <= 3'b000;
      vblank_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      mode_q       <= mode_d;
      fb_rd_q      <= issue && (x_q < X_END);
      if (issue && (x_q < X_END)) fb_addr_q <= {y_q, x_q};
      idx_s1_q     <= idx_s1_d;
      use_fb_q     <= issue && use_fb_d;
      re_d1_q      <= issue;
      re_d2_q      <= re_d1_q;
      sync_d1_q    <= sync_signal;
      sync_d2_q    <= sync_d1_q;
      pix_q        <= idx_to_level(use_fb_q ? fb_data : idx_s1_q);
      vblank_q     <= vblank;
      frame_tick_q <= vblank & ~vblank_q;
    end
  end

  assign fb_rd      = fb_rd_q;
  assign fb_addr    = fb_addr_q;
  assign video_out  = re_d2_q ? pix_q : sync_d2_q;
  assign line_count = y_q;
  assign frame_tick = frame_tick_q;

endmodule
